// File: rtl/tc_multi.sv
// rtl/tc_multi.sv - multi-channel timer/counter with prescaler, PWM compare outputs and masked interrupt
// Double-buffered TOP/OCR, four counting modes, W1C and ack-based interrupt flag clearing.
module tc_multi #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             t0,
  output logic [NCH-1:0]   oc,
  output logic             irq,
  input  logic             irq_ack
);
  localparam logic [1:0]       MODE_NORMAL = 2'd0;
  localparam logic [1:0]       MODE_CTC    = 2'd1;
  localparam logic [1:0]       MODE_FPWM   = 2'd2;
  localparam logic [1:0]       MODE_PC     = 2'd3;
  localparam logic [WIDTH-1:0] ONE_W       = 1;
  localparam logic [NCH:0]     ONE_F       = 1;

  logic [4:0]       ctrl_q, ctrl_d;
  logic [2*NCH-1:0] com_q, com_d;
  logic [WIDTH-1:0] tcnt_q, tcnt_d, top_buf_q, top_buf_d, top_act_q, top_act_d;
  logic [WIDTH-1:0] ocr_buf_q [NCH];
  logic [WIDTH-1:0] ocr_buf_d [NCH];
  logic [WIDTH-1:0] ocr_act_q [NCH];
  logic [WIDTH-1:0] ocr_act_d [NCH];
  logic [NCH:0]     imsk_q, imsk_d, ifr_q, ifr_d;
  logic [9:0]       presc_q, presc_d;
  logic             t0_s1_q, t0_s2_q, t0_s3_q;
  logic             dir_q, dir_d;
  logic [NCH-1:0]   oc_q, oc_d;
  logic             irq_q, irq_d;

  logic [1:0]       mode;
  logic [2:0]       cs;
  logic             tick_raw, tick, tcnt_wr, ctrl_wr;
  logic             cnt_up, dir_nxt, tov, wrap, load;
  logic [WIDTH-1:0] tcnt_nxt;
  logic [NCH-1:0]   match;
  logic [NCH:0]     hw_set, w1c, pend, ack_clr;

  assign mode    = ctrl_q[4:3];
  assign cs      = ctrl_q[2:0];
  assign tcnt_wr = write && (addr == 4'd2);
  assign ctrl_wr = write && (addr == 4'd0);
  assign tick    = tick_raw && !tcnt_wr;
  assign oc      = oc_q;
  assign irq     = irq_q;

  always_comb begin
    presc_d = (cs == 3'd0) ? 10'd0 : presc_q + 10'd1;
    case (cs)
      3'd1:    tick_raw = 1'b1;
      3'd2:    tick_raw = &presc_q[2:0];
      3'd3:    tick_raw = &presc_q[5:0];
      3'd4:    tick_raw = &presc_q[7:0];
      3'd5:    tick_raw = &presc_q;
      3'd6:    tick_raw = !t0_s2_q && t0_s3_q;
      3'd7:    tick_raw = t0_s2_q && !t0_s3_q;
      default: tick_raw = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    com_d     = com_q;
    top_buf_d = top_buf_q;
    imsk_d    = imsk_q;
    ocr_buf_d = ocr_buf_q;
    if (write) begin
      case (addr)
        4'd0:    ctrl_d    = wdata[4:0];
        4'd1:    com_d     = wdata[2*NCH-1:0];
        4'd3:    top_buf_d = wdata;
        4'd8:    imsk_d    = wdata[NCH:0];
        default: ;
      endcase
      for (int i = 0; i < NCH; i++)
        if (addr == 4'(4 + i)) ocr_buf_d[i] = wdata;
    end
  end

  // dir_q=1 means counting down (phase-correct mode only)
  always_comb begin
    tcnt_nxt = tcnt_q + ONE_W;
    dir_nxt  = dir_q;
    cnt_up   = 1'b1;
    case (mode)
      MODE_CTC, MODE_FPWM: begin
        if (tcnt_q == top_act_q) tcnt_nxt = '0;
      end
      MODE_PC: begin
        if (top_act_q == '0) begin
          tcnt_nxt = '0;
        end else if (!dir_q && tcnt_q == top_act_q) begin
          tcnt_nxt = tcnt_q - ONE_W;
          dir_nxt  = 1'b1;
          cnt_up   = 1'b0;
        end else if (dir_q && tcnt_q == '0) begin
          dir_nxt = 1'b0;
        end else if (dir_q) begin
          tcnt_nxt = tcnt_q - ONE_W;
          cnt_up   = 1'b0;
        end
      end
      default: ;
    endcase
    wrap = tick && (tcnt_nxt == '0);
    tov  = wrap && (mode != MODE_PC || !cnt_up);
    case (mode)
      MODE_FPWM: load = wrap;
      MODE_PC:   load = tick && cnt_up && (tcnt_nxt == top_act_q);
      default:   load = 1'b1;
    endcase
    tcnt_d    = tcnt_wr ? wdata : (tick ? tcnt_nxt : tcnt_q);
    dir_d     = (ctrl_wr || mode != MODE_PC) ? 1'b0 : (tick ? dir_nxt : dir_q);
    top_act_d = load ? top_buf_q : top_act_q;
  end

  // Matches compare against the value active after this cycle's load
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ocr_act_d[i] = load ? ocr_buf_q[i] : ocr_act_q[i];
      match[i]     = tick && (tcnt_nxt == ocr_act_d[i]);
      oc_d[i]      = oc_q[i];
      case (mode)
        MODE_NORMAL, MODE_CTC: begin
          case (com_q[2*i +: 2])
            2'd0:    oc_d[i] = 1'b0;
            2'd1:    if (match[i]) oc_d[i] = !oc_q[i];
            2'd2:    if (match[i]) oc_d[i] = 1'b0;
            default: if (match[i]) oc_d[i] = 1'b1;
          endcase
        end
        MODE_FPWM: begin
          if (!com_q[2*i+1])   oc_d[i] = 1'b0;
          else if (match[i])   oc_d[i] = com_q[2*i];
          else if (wrap)       oc_d[i] = !com_q[2*i];
        end
        default: begin
          if (!com_q[2*i+1])                        oc_d[i] = 1'b0;
          else if (match[i] && top_act_q != '0)     oc_d[i] = cnt_up ? com_q[2*i] : !com_q[2*i];
        end
      endcase
    end
  end

  always_comb begin
    hw_set  = {match, tov};
    w1c     = (write && addr == 4'd9) ? wdata[NCH:0] : '0;
    pend    = ifr_q & imsk_q;
    ack_clr = irq_ack ? (pend & (~pend + ONE_F)) : '0;
    ifr_d   = (ifr_q & ~w1c & ~ack_clr) | hw_set;
    irq_d   = |pend;
  end

  always_comb begin
    rdata = '0;
    if (read) begin
      case (addr)
        4'd0:    rdata[4:0]       = ctrl_q;
        4'd1:    rdata[2*NCH-1:0] = com_q;
        4'd2:    rdata            = tcnt_q;
        4'd3:    rdata            = top_buf_q;
        4'd8:    rdata[NCH:0]     = imsk_q;
        4'd9:    rdata[NCH:0]     = ifr_q;
        default: begin
          for (int i = 0; i < NCH; i++)
            if (addr == 4'(4 + i)) rdata = ocr_buf_q[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      com_q     <= '0;
      tcnt_q    <= '0;
      top_buf_q <= '0;
      top_act_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        ocr_buf_q[i] <= '0;
        ocr_act_q[i] <= '0;
      end
      imsk_q  <= '0;
      ifr_q   <= '0;
      presc_q <= '0;
      t0_s1_q <= 1'b0;
      t0_s2_q <= 1'b0;
      t0_s3_q <= 1'b0;
      dir_q   <= 1'b0;
      oc_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      com_q     <= com_d;
      tcnt_q    <= tcnt_d;
      top_buf_q <= top_buf_d;
      top_act_q <= top_act_d;
      for (int i = 0; i < NCH; i++) begin
        ocr_buf_q[i] <= ocr_buf_d[i];
        ocr_act_q[i] <= ocr_act_d[i];
      end
      imsk_q  <= imsk_d;
      ifr_q   <= ifr_d;
      presc_q <= presc_d;
      t0_s1_q <= t0;
      t0_s2_q <= t0_s1_q;
      t0_s3_q <= t0_s2_q;
      dir_q   <= dir_d;
      oc_q    <= oc_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_tc_multi.sv
// tb/tb_tc_multi.sv - directed self-checking bench for tc_multi (WIDTH=8, NCH=2)
module tb_tc_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       irq_ack = 1'b0;
  logic       t0 = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic [1:0] oc;
  logic       irq;

  int total = 0;
  int bad = 0;
  int cnt;
  logic [7:0] v;
  logic [7:0] exp_t   [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2};
  logic       exp_oc  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       exp_tov [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  tc_multi #(.WIDTH(8), .NCH(2)) dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .addr(addr), .wdata(wdata),
    .rdata(rdata), .t0(t0), .oc(oc), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    write = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    read = 1'b1;
    addr = a;
    #1;
    d = rdata;
    read = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step(3);
    rst = 1'b0;
    addr = 4'd2;
    #1;
    chk("rdata_idle", 16'(rdata), 16'h0);
    chk("oc_reset", 16'(oc), 16'h0);
    chk("irq_reset", 16'(irq), 16'h0);
    rd(4'd0, v); chk("ctrl_reset", 16'(v), 16'h0);
    rd(4'd2, v); chk("tcnt_reset", 16'(v), 16'h0);
    rd(4'd9, v); chk("ifr_reset", 16'(v), 16'h0);

    // unmapped offsets and OCR beyond NCH
    step(1);
    wr(4'd6, 8'hAA);
    rd(4'd6, v); chk("ocr2_ignored", 16'(v), 16'h0);
    rd(4'hA, v); chk("unmapped_read", 16'(v), 16'h0);

    // mode 0 wrap, TOV and irq
    wr(4'd8, 8'h01);
    wr(4'd2, 8'hFE);
    wr(4'd0, 8'h01);
    rd(4'd2, v); chk("m0_tcnt_fe", 16'(v), 16'hFE);
    step(1);
    rd(4'd2, v); chk("m0_tcnt_ff", 16'(v), 16'hFF);
    rd(4'd9, v); chk("m0_ifr_pre", 16'(v), 16'h0);
    step(1);
    rd(4'd2, v); chk("m0_tcnt_wrap", 16'(v), 16'h00);
    rd(4'd9, v); chk("m0_ifr_wrap", 16'(v), 16'h7);
    chk("m0_irq_lag", 16'(irq), 16'h0);
    step(1);
    chk("m0_irq", 16'(irq), 16'h1);
    rd(4'd2, v); chk("m0_tcnt_1", 16'(v), 16'h01);
    wr(4'd0, 8'h00);
    wr(4'd9, 8'h07);
    rd(4'd9, v); chk("ifr_w1c", 16'(v), 16'h0);

    // mode 2 fast PWM, TOP=9
    wr(4'd2, 8'd0);
    wr(4'd3, 8'd9);
    wr(4'd4, 8'd3);
    wr(4'd5, 8'd7);
    wr(4'd1, 8'h02);
    wr(4'd0, 8'h11);
    step(10);
    chk("pwm_set_at_wrap", 16'(oc[0]), 16'h1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin cnt += int'(oc[0]); step(1); end
    chk("pwm_duty_3", 16'(cnt), 16'd6);
    wr(4'd4, 8'd5);
    step(2);
    chk("pwm_old_ocr", 16'(oc[0]), 16'h0);
    step(11);
    chk("pwm_new_ocr_hi", 16'(oc[0]), 16'h1);
    step(1);
    chk("pwm_new_ocr_lo", 16'(oc[0]), 16'h0);
    wr(4'd4, 8'd12);
    step(5);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin cnt += int'(oc[0]); step(1); end
    chk("pwm_ocr_gt_top", 16'(cnt), 16'd20);
    wr(4'd4, 8'd0);
    step(9);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin cnt += int'(oc[0]); step(1); end
    chk("pwm_ocr_zero", 16'(cnt), 16'd0);
    rd(4'd9, v); chk("pwm_ifr", 16'(v), 16'h7);
    wr(4'd0, 8'h00);
    wr(4'd9, 8'h07);

    // mode 3 phase-correct, TOP=4, OCR0=2
    wr(4'd2, 8'd0);
    wr(4'd3, 8'd4);
    wr(4'd4, 8'd2);
    wr(4'd5, 8'd7);
    wr(4'd0, 8'h19);
    for (int k = 0; k < 10; k++) begin
      step(1);
      rd(4'd2, v); chk($sformatf("pc_tcnt_%0d", k), 16'(v), 16'(exp_t[k]));
      chk($sformatf("pc_oc_%0d", k), 16'(oc[0]), 16'(exp_oc[k]));
      rd(4'd9, v); chk($sformatf("pc_tov_%0d", k), 16'(v[0]), 16'(exp_tov[k]));
    end
    rd(4'd9, v); chk("pc_ifr", 16'(v), 16'h3);
    wr(4'd0, 8'h00);
    wr(4'd9, 8'h07);

    // prescaler /64 and t0 rising edge
    wr(4'd2, 8'h10);
    wr(4'd0, 8'h03);
    step(63);
    rd(4'd2, v); chk("presc64_before", 16'(v), 16'h10);
    step(1);
    rd(4'd2, v); chk("presc64_first", 16'(v), 16'h11);
    wr(4'd0, 8'h00);
    wr(4'd0, 8'h07);
    t0 = 1'b1;
    step(1);
    step(1);
    rd(4'd2, v); chk("t0_not_yet", 16'(v), 16'h11);
    step(1);
    rd(4'd2, v); chk("t0_tick", 16'(v), 16'h12);
    step(3);
    rd(4'd2, v); chk("t0_single", 16'(v), 16'h12);
    t0 = 1'b0;
    step(4);
    rd(4'd2, v); chk("t0_fall_ignored", 16'(v), 16'h12);
    wr(4'd0, 8'h00);

    // irq_ack clears lowest pending flag
    wr(4'd4, 8'd0);
    wr(4'd5, 8'd5);
    wr(4'd9, 8'h07);
    wr(4'd8, 8'h03);
    wr(4'd2, 8'hFF);
    wr(4'd0, 8'h01);
    wr(4'd0, 8'h00);
    rd(4'd9, v); chk("ack_ifr_init", 16'(v), 16'h3);
    step(1);
    chk("ack_irq_init", 16'(irq), 16'h1);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    rd(4'd9, v); chk("ack1_ifr", 16'(v), 16'h2);
    chk("ack1_irq", 16'(irq), 16'h1);
    step(1);
    chk("ack1_irq_hold", 16'(irq), 16'h1);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    rd(4'd9, v); chk("ack2_ifr", 16'(v), 16'h0);
    step(1);
    chk("ack2_irq", 16'(irq), 16'h0);

    // reset mid-count overrides a simultaneous write
    wr(4'd1, 8'h03);
    wr(4'd4, 8'd5);
    wr(4'd2, 8'd0);
    wr(4'd0, 8'h01);
    step(6);
    chk("pre_rst_oc", 16'(oc), 16'h1);
    chk("pre_rst_irq", 16'(irq), 16'h1);
    rst = 1'b1;
    write = 1'b1;
    addr = 4'd2;
    wdata = 8'h55;
    step(1);
    rst = 1'b0;
    write = 1'b0;
    chk("rst_oc", 16'(oc), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    rd(4'd2, v); chk("rst_tcnt", 16'(v), 16'h0);
    rd(4'd0, v); chk("rst_ctrl", 16'(v), 16'h0);
    rd(4'd1, v); chk("rst_com", 16'(v), 16'h0);
    rd(4'd4, v); chk("rst_ocr0", 16'(v), 16'h0);
    rd(4'd9, v); chk("rst_ifr", 16'(v), 16'h0);
    step(3);
    rd(4'd2, v); chk("rst_stopped", 16'(v), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tc_multi.md
TC_MULTI -- requirements
Module: tc_multi

Interface
REQ-001 SHALL take parameter WIDTH, default 16, counter/compare/bus width, legal 8..16.
REQ-002 SHALL take parameter NCH, default 2, number of compare channels, legal 1..4.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have write  input  1  register write strobe, single cycle.
REQ-006 SHALL have read  input  1  register read strobe.
REQ-007 SHALL have addr  input  4  register offset.
REQ-008 SHALL have wdata  input  WIDTH  write data.
REQ-009 SHALL have rdata  output  WIDTH  read data, combinational, 0 when read=0 or offset unmapped.
REQ-010 SHALL have t0  input  1  asynchronous external count pin.
REQ-011 SHALL have oc  output  NCH  registered compare outputs.
REQ-012 SHALL have irq  output  1  registered interrupt request.
REQ-013 SHALL have irq_ack  input  1  one-cycle interrupt-serviced pulse.

Function
REQ-014 SHALL map registers: 0 CTRL {MODE[4:3], CS[2:0]}; 1 COM {2 bits per channel n at [2n+1:2n]}; 2 TCNT; 3 TOP; 4+n OCRn; 8 IMSK[NCH:0]; 9 IFR[NCH:0]; unused bits read 0, writes to OCRn with n>=NCH ignored.
REQ-015 SHALL generate tick per CS: 0 stopped; 1 every clk; 2/3/4/5 every 8/64/256/1024 clk; 6 t0 falling; 7 t0 rising.
REQ-016 SHALL clear the prescaler while CS=0 so the first divided tick occurs exactly N clocks after CS becomes nonzero.
REQ-017 SHALL synchronise t0 through two flops plus one edge-detect flop; tick asserted 2 clocks after the edge that first samples the new level.
REQ-018 SHALL, on a tick, advance TCNT per MODE: 0 normal (+1, wrap MAX->0); 1 CTC and 2 fast PWM (+1, TCNT==TOP -> 0, TCNT>TOP counts to MAX then 0); 3 phase-correct (up 0..TOP, down TOP..0, period 2*TOP ticks).
REQ-019 SHALL keep a direction bit for mode 3: up at TCNT==TOP turns down (next TOP-1); down at TCNT==0 turns up (next 1); direction forced up on any CTRL write or mode!=3.
REQ-020 SHALL, with TOP=0, hold TCNT at 0: modes 1/2 set TOV every tick; mode 3 sets no TOV and holds oc.
REQ-021 SHALL define match event n as a tick whose new TCNT value equals active OCRn.
REQ-022 SHALL set IFR bit 0 (TOV) on the tick the counter wraps to 0 (modes 0/1/2) or reaches 0 counting down (mode 3); IFR bit n+1 (OCFn) on match event n.
REQ-023 SHALL double-buffer TOP and OCRn: modes 0/1 load active from buffer every clock; mode 2 loads on the tick wrapping to 0; mode 3 loads on the tick reaching TOP; a buffer write in the load cycle loads the old buffer value.
REQ-024 SHALL drive oc[n] in modes 0/1 per COM: 0 -> 0, 1 toggle, 2 clear, 3 set on match.
REQ-025 SHALL drive oc[n] in mode 2: COM 2 set at wrap to 0, clear on match, match wins on the same tick; COM 3 inverted; COM 0/1 -> 0 (duty = OCR/(TOP+1), OCR>TOP gives 100%).
REQ-026 SHALL drive oc[n] in mode 3: COM 2 clear on up-count match, set on down-count match; COM 3 inverted; COM 0/1 -> 0.
REQ-027 SHALL, on TCNT write, load wdata and suppress tick, match and TOV that cycle; prescaler unaffected.
REQ-028 SHALL clear IFR bits written 1 at offset 9; hardware set wins over W1C in the same cycle.
REQ-029 SHALL, on irq_ack, clear the lowest-numbered bit set in IFR&IMSK; hardware set of that bit in the same cycle wins.
REQ-030 SHALL register irq = |(IFR&IMSK), one clock after the flag appears in IFR.
REQ-031 SHALL keep TCNT, buffers and IFR unchanged on CTRL writes (mode change mid-count continues from current TCNT).

Reset
REQ-032 SHALL on rst clear CTRL, COM, TCNT, TOP, all OCR buffers/active, IMSK, IFR, prescaler, sync flops, direction; oc=0, irq=0; rst overrides simultaneous write.

Verification
REQ-033 Mode 0, WIDTH=8, CS=1, TCNT=0xFE -> TCNT 0xFF, 0x00; IFR[0]=1 on wrap tick; irq=1 next clock with IMSK[0]=1.
REQ-034 Mode 2, TOP=9, OCR0=3, COM0=2, CS=1 -> oc[0] high 3 of every 10 clocks; OCR0=12 -> constant high; OCR0=0 -> constant low.
REQ-035 Mode 3, TOP=4, OCR0=2, COM0=2 -> TCNT 0,1,2,3,4,3,2,1,0,1; oc[0] clears at up 2, sets at down 2; TOV at 0.
REQ-036 Mode 2 running, OCR0 written mid-period -> old value used until wrap, new value from next period.
REQ-037 CS=3 written -> first tick 64 clocks later; CS=7, t0 rises -> exactly one tick 2 clocks after sampling.
REQ-038 IFR=0b011, IMSK=0b011, irq_ack -> IFR=0b010, irq stays 1; second ack -> IFR=0, irq=0 next clock; rst mid-count -> all outputs 0.
